// File: rtl/cache_control.sv
// cache_control: direct-mapped L1 sequencer for hit/miss, write-back and line fill.
// Also keeps saturating hit and miss counters.
module cache_control #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_mask   = 2**s_offset
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [3:0]          mem_byte_enable,
    output logic                mem_resp,
    input  logic                hit,
    input  logic                dirty,
    output logic                data_read,
    output logic [s_mask-1:0]   data_write_en,
    output logic                data_in_sel,
    output logic                load_tag,
    output logic                set_valid,
    output logic                set_dirty,
    output logic                clear_dirty,
    output logic                pmem_addr_sel,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    input  logic [s_offset-1:0] mem_address_offset,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);
    localparam int unused_sets = 2**s_index;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t      state_q, state_d;
    logic [31:0] hit_q, hit_d, miss_q, miss_d;
    logic        refill_q, refill_d;
    logic        unused_ok;

    assign unused_ok  = ^mem_address_offset[1:0];
    assign pmem_read  = state_q == FILL;
    assign pmem_write = state_q == WRITEBACK;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hit_q    <= '0;
            miss_q   <= '0;
            refill_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            refill_q <= refill_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        hit_d         = hit_q;
        miss_d        = miss_q;
        refill_d      = 1'b0;
        mem_resp      = 1'b0;
        data_read     = 1'b0;
        data_write_en = '0;
        data_in_sel   = 1'b0;
        load_tag      = 1'b0;
        set_valid     = 1'b0;
        set_dirty     = 1'b0;
        clear_dirty   = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (hit) begin
                        mem_resp  = 1'b1;
                        data_read = 1'b1;
                        hit_d     = hit_q + 32'(~&hit_q);
                        if (mem_write) begin
                            data_write_en = s_mask'(mem_byte_enable) << {mem_address_offset[s_offset-1:2], 2'b00};
                            set_dirty     = 1'b1;
                        end
                    end else begin
                        // the lookup right after a fill is the same request, not a new miss
                        miss_d  = refill_q ? miss_q : miss_q + 32'(~&miss_q);
                        state_d = dirty ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                data_read     = 1'b1;
                pmem_addr_sel = 1'b1;
                state_d       = pmem_resp ? FILL : WRITEBACK;
            end
            FILL: begin
                if (pmem_resp) begin
                    data_write_en = '1;
                    data_in_sel   = 1'b1;
                    load_tag      = 1'b1;
                    set_valid     = 1'b1;
                    clear_dirty   = 1'b1;
                    refill_d      = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: randomized scoreboard bench with a line-status reference model
// and a small tag/valid/dirty datapath driven by the controller's strobes.
module tb_cache_control;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [3:0]  mem_byte_enable = '0;
    logic        mem_resp, hit, dirty, data_read, data_in_sel;
    logic [31:0] data_write_en;
    logic        load_tag, set_valid, set_dirty, clear_dirty, pmem_addr_sel;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [31:0] hit_count, miss_count;

    logic [1:0]  a_tag = '0;
    logic [2:0]  a_idx = '0;
    logic [4:0]  a_off = '0;
    logic        auto_r, man_r = 1'b0, block = 1'b0, init = 1'b1;
    int          wb_delay = 1, fill_delay = 1, cnt, cyc = 0, start_cyc = 0;
    int          errors = 0, checks = 0;

    logic        env_v [8];
    logic [1:0]  env_t [8];
    logic        env_d [8];

    bit          ref_v [8];
    logic [1:0]  ref_t [8];
    bit          ref_d [8];
    logic [31:0] ref_hit = '0, ref_miss = '0;

    typedef struct {
        int          lat;
        logic [31:0] hits;
        logic [31:0] misses;
        logic [31:0] wen;
        bit          wr;
    } exp_t;
    exp_t q[$];

    cache_control dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .hit(hit), .dirty(dirty),
        .data_read(data_read), .data_write_en(data_write_en), .data_in_sel(data_in_sel),
        .load_tag(load_tag), .set_valid(set_valid), .set_dirty(set_dirty),
        .clear_dirty(clear_dirty), .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp), .mem_address_offset(a_off),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign pmem_resp = auto_r | man_r;
    assign hit   = env_v[a_idx] && env_t[a_idx] == a_tag;
    assign dirty = env_v[a_idx] && env_d[a_idx];

    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 8; k++) begin
                env_v[k] <= 1'b0;
                env_t[k] <= '0;
                env_d[k] <= 1'b0;
            end
        end else begin
            if (load_tag) env_t[a_idx] <= a_tag;
            if (set_valid) env_v[a_idx] <= 1'b1;
            if (set_dirty) env_d[a_idx] <= 1'b1;
            if (clear_dirty) env_d[a_idx] <= 1'b0;
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return v == 32'hFFFF_FFFF ? v : v + 32'd1;
    endfunction

    // physical memory: answers after wb_delay / fill_delay cycles of request
    initial begin
        auto_r = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            auto_r = 1'b0;
            if (rst_n && !block && (pmem_read || pmem_write)) begin
                cnt++;
                if (cnt >= (pmem_write ? wb_delay : fill_delay)) begin
                    auto_r = 1'b1;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            chk("pmem_excl", 32'(pmem_read & pmem_write), 32'd0);
            if (mem_resp) begin
                if (q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
                    chk("hit_count", hit_count, e.hits);
                    chk("miss_count", miss_count, e.misses);
                    chk("write_en", data_write_en, e.wen);
                    chk("resp_ctl", 32'({data_read, set_dirty, data_in_sel, load_tag, pmem_read, pmem_write}),
                        32'({1'b1, e.wr, 4'b0000}));
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [1:0] t, input logic [2:0] i, input logic [4:0] o,
                          input logic [3:0] be, input int wd, input int fd);
        exp_t e;
        int n;
        if (ref_v[i] && ref_t[i] == t) e.lat = 0;
        else begin
            e.lat = (ref_v[i] && ref_d[i] ? wd : 0) + fd + 1;
            ref_miss = sat(ref_miss);
            ref_v[i] = 1'b1;
            ref_t[i] = t;
            ref_d[i] = 1'b0;
        end
        e.hits = ref_hit;
        e.misses = ref_miss;
        ref_hit = sat(ref_hit);
        e.wr = wr;
        e.wen = wr ? 32'(be) << (o[4:2] * 4) : 32'd0;
        if (wr) ref_d[i] = 1'b1;
        q.push_back(e);
        @(posedge clk);
        #1;
        a_tag = t; a_idx = i; a_off = o; mem_byte_enable = be;
        wb_delay = wd; fill_delay = fd;
        mem_read = !wr; mem_write = wr;
        start_cyc = cyc;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (mem_resp) break;
            if (++n > 100) begin
                chk("resp_timeout", 32'd0, 32'd1);
                q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_pmem(input string n);
        int k;
        k = 0;
        while (!(pmem_read || pmem_write) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk(n, 32'd0, 32'd1);
    endtask

    initial begin
        logic [2:0] i;
        logic [1:0] t;
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [2:0] i;
        logic [1:0] t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", 32'({mem_resp, data_read, data_in_sel, load_tag, set_valid, set_dirty,
                             clear_dirty, pmem_addr_sel, pmem_read, pmem_write}), 32'd0);
        chk("rst_wen", data_write_en, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init = 1'b0;

        do_req(1'b0, 2'd1, 3'd2, 5'h00, 4'h0, 1, 4);
        do_req(1'b0, 2'd1, 3'd2, 5'h04, 4'h0, 1, 1);
        do_req(1'b1, 2'd1, 3'd2, 5'h08, 4'b0101, 1, 1);
        do_req(1'b1, 2'd3, 3'd2, 5'h1C, 4'b1111, 3, 2);
        for (int n = 0; n < 150; n++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                   $urandom_range(1, 5), $urandom_range(1, 5));

        // request withdrawn while the miss is in flight
        i = 3'($urandom_range(0, 7));
        t = ref_t[i] + 2'd1;
        ref_miss = sat(ref_miss);
        ref_v[i] = 1'b1; ref_t[i] = t; ref_d[i] = 1'b0;
        @(posedge clk);
        #1;
        a_tag = t; a_idx = i; wb_delay = 2; fill_delay = 3; mem_read = 1'b1;
        @(negedge clk);
        wait_pmem("drop_pmem_timeout");
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        repeat (10) @(negedge clk);
        chk("drop_miss", miss_count, ref_miss);
        chk("drop_hits", hit_count, ref_hit);
        chk("drop_idle", 32'({pmem_read, pmem_write}), 32'd0);

        // reset while the line transfer is outstanding
        block = 1'b1;
        i = 3'($urandom_range(0, 7));
        t = ref_t[i] + 2'd1;
        @(posedge clk);
        #1;
        a_tag = t; a_idx = i; mem_read = 1'b1;
        @(negedge clk);
        wait_pmem("abort_pmem_timeout");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("async_drop", 32'({pmem_read, pmem_write}), 32'd0);
        ref_hit = '0;
        ref_miss = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        man_r = 1'b1;
        @(negedge clk);
        chk("abort_quiet", 32'({mem_resp, |data_write_en, load_tag, set_valid, set_dirty, clear_dirty,
                                 pmem_read, pmem_write}), 32'd0);
        @(posedge clk);
        #1;
        man_r = 1'b0;
        block = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", 32'({mem_resp, |data_write_en, load_tag, set_valid, set_dirty, clear_dirty,
                                     pmem_read, pmem_write}), 32'd0);
        end
        chk("abort_hits", hit_count, 32'd0);
        chk("abort_misses", miss_count, 32'd0);

        // miss counter saturation
        @(negedge clk);
        force dut.miss_q = 32'hFFFF_FFFE;
        #1;
        release dut.miss_q;
        ref_miss = 32'hFFFF_FFFE;
        chk("sat_preload", miss_count, 32'hFFFF_FFFE);
        for (int n = 0; n < 2; n++) begin
            i = 3'($urandom_range(0, 7));
            do_req(1'b0, ref_t[i] + 2'd1, i, 5'h00, 4'h0, 2, 2);
        end
        @(negedge clk);
        chk("sat_hold", miss_count, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
